// File: rtl/paint_pkg.sv
// rtl/paint_pkg.sv - shared paint-core constants: cursor FSM encoding and delay-unit handshake levels
package paint_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ARM    = 3'd1;
    localparam logic [2:0] ST_START  = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_TOGGLE = 3'd4;
    localparam logic [2:0] ST_PARK   = 3'd5;

    // Active levels every initiator of the shared white-count delay unit must use
    localparam logic DELAY_RST_ASSERT  = 1'b1;
    localparam logic DELAY_INIT_ASSERT = 1'b1;
    localparam logic DELAY_DONE_ASSERT = 1'b1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/blink_period_cnt.sv
// rtl/blink_period_cnt.sv - phase-aware delay-period counter with terminal-count flag
module blink_period_cnt
    import paint_pkg::*;
#(
    parameter int VIS_PERIODS = 2,
    parameter int HID_PERIODS = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    input  logic phase,
    output logic phase_end
);

    localparam int CNT_W = $clog2(max_int(VIS_PERIODS, HID_PERIODS) + 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] last;

    // phase=1 is the visible phase; the flag marks the period that completes it
    assign last      = phase ? CNT_W'(VIS_PERIODS - 1) : CNT_W'(HID_PERIODS - 1);
    assign phase_end = (cnt == last);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= phase_end ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cursor_blink_ctrl.sv
// rtl/cursor_blink_ctrl.sv - cursor blink FSM driving the delay-unit handshake; CURSOR_IDLE_EN builds idle parking
module cursor_blink_ctrl
    import paint_pkg::*;
#(
    parameter int VIS_PERIODS = 2,
    parameter int HID_PERIODS = 1,
    parameter int IDLE_BLINKS = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic move,
    input  logic delay_done,
    output logic delay_init,
    output logic delay_rst,
    output logic cursor_on,
    output logic blink_tick,
    output logic idle
);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       cursor_nxt;
    logic       tick_nxt;
    logic       restart;
    logic       toggling;
    logic       phase_end;
    logic       idle_last;

    // Disable, a move, or leaving IDLE all begin a fresh visible phase
    assign restart  = !en || (move && state != ST_IDLE) || state == ST_IDLE;
    assign toggling = en && !move && state == ST_TOGGLE;

    blink_period_cnt #(
        .VIS_PERIODS(VIS_PERIODS),
        .HID_PERIODS(HID_PERIODS)
    ) u_period_cnt (
        .clk      (clk),
        .rst      (rst),
        .inc      (toggling),
        .clr      (restart),
        .phase    (cursor_on),
        .phase_end(phase_end)
    );

    always_comb begin
        state_nxt  = state;
        cursor_nxt = cursor_on;
        tick_nxt   = 1'b0;
        if (!en) begin
            state_nxt  = ST_IDLE;
            cursor_nxt = 1'b1;
            tick_nxt   = !cursor_on;
        end else if (move && state != ST_IDLE) begin
            state_nxt  = ST_ARM;
            cursor_nxt = 1'b1;
            tick_nxt   = !cursor_on;
        end else begin
            case (state)
                ST_IDLE:  state_nxt = ST_ARM;
                ST_ARM:   state_nxt = ST_START;
                ST_START: state_nxt = ST_WAIT;
                ST_WAIT: begin
                    if (delay_done == DELAY_DONE_ASSERT) begin
                        state_nxt = ST_TOGGLE;
                    end
                end
                ST_TOGGLE: begin
                    state_nxt = ST_ARM;
                    if (phase_end) begin
                        cursor_nxt = !cursor_on;
                        tick_nxt   = 1'b1;
                        if (!cursor_on && idle_last) begin
                            state_nxt = ST_PARK;
                        end
                    end
                end
                ST_PARK:  state_nxt = ST_PARK;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cursor_on  <= 1'b1;
            blink_tick <= 1'b0;
        end else begin
            state      <= state_nxt;
            cursor_on  <= cursor_nxt;
            blink_tick <= tick_nxt;
        end
    end

    assign delay_init = (state == ST_START) ? DELAY_INIT_ASSERT : ~DELAY_INIT_ASSERT;
    assign delay_rst  = (state == ST_IDLE || state == ST_ARM || state == ST_PARK)
                        ? DELAY_RST_ASSERT : ~DELAY_RST_ASSERT;

`ifdef CURSOR_IDLE_EN
    localparam int IDLE_W = $clog2(IDLE_BLINKS + 1);

    logic [IDLE_W-1:0] idle_cnt;

    // Counts completed hidden phases; saturates once the cursor has parked
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            idle_cnt <= '0;
        end else if (toggling && phase_end && !cursor_on && idle_cnt != IDLE_W'(IDLE_BLINKS)) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign idle_last = (idle_cnt == IDLE_W'(IDLE_BLINKS - 1));
    assign idle      = (state == ST_PARK);
`else
    assign idle_last = 1'b0;
    // IDLE_BLINKS only matters when parking is built
    assign idle      = (IDLE_BLINKS < 0);
`endif

endmodule

// File: tb/tb_cursor_blink_ctrl.sv
// tb/tb_cursor_blink_ctrl.sv - randomized bench for cursor_blink_ctrl against a period-arithmetic model
module tb_cursor_blink_ctrl;

    localparam int VIS  = 2;
    localparam int HID  = 1;
    localparam int IB   = 3;
    localparam int DLY  = 10;
    localparam int PER  = DLY + 3;
    localparam int NCYC = VIS + HID;
`ifdef CURSOR_IDLE_EN
    localparam bit IDLE_EN = 1'b1;
`else
    localparam bit IDLE_EN = 1'b0;
`endif

    logic clk, rst, en, move, delay_done;
    logic delay_init, delay_rst, cursor_on, blink_tick, idle;

    cursor_blink_ctrl #(
        .VIS_PERIODS(VIS),
        .HID_PERIODS(HID),
        .IDLE_BLINKS(IB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .move      (move),
        .delay_done(delay_done),
        .delay_init(delay_init),
        .delay_rst (delay_rst),
        .cursor_on (cursor_on),
        .blink_tick(blink_tick),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    // Delay unit: done rises DLY cycles after init, cleared while delay_rst is high
    int dcnt = 0;
    always @(negedge clk) begin
        if (delay_rst === 1'b1) begin
            dcnt = 0;
            delay_done = 1'b0;
        end else if (delay_init === 1'b1) begin
            dcnt = DLY;
        end else if (dcnt > 0) begin
            dcnt = dcnt - 1;
            if (dcnt == 0) delay_done = 1'b1;
        end
    end

    wire [4:0] got = {delay_init, delay_rst, cursor_on, blink_tick, idle};

    int   n_vec = 0;
    int   n_bad = 0;
    int   m_t = 0;
    bit   m_active = 1'b0;
    logic m_cur = 1'b1;
    logic [4:0] exp_vec;

    // Model: m_t counts edges since the last restart; each delay period is PER edges
    task automatic step(input logic e, input logic mv, input logic r);
        logic prev;
        int   p;
        @(negedge clk);
        en = e;
        move = mv;
        rst = r;
        @(posedge clk);
        #1;
        prev = m_cur;
        if (r || !e) begin
            m_active = 1'b0;
        end else if (!m_active || mv) begin
            m_active = 1'b1;
            m_t = 0;
        end else begin
            m_t = m_t + 1;
        end
        if (!m_active) begin
            m_cur = 1'b1;
            exp_vec = 5'b01100;
        end else begin
            p = m_t / PER;
            if (IDLE_EN && p >= IB * NCYC) begin
                m_cur = 1'b1;
                exp_vec = 5'b01101;
            end else begin
                m_cur = ((p % NCYC) < VIS);
                exp_vec = {(m_t % PER == 1), (m_t % PER == 0), m_cur, 1'b0, 1'b0};
            end
        end
        exp_vec[1] = !r && (m_cur != prev);
    endtask

    task automatic test_reset();
        step(1, 0, 1);
        n_vec++;
        if (got !== 5'b01100) begin
            n_bad++;
            $display("FAIL reset_en got=%b exp=01100", got);
        end
        step(0, 0, 1);
        n_vec++;
        if (got !== exp_vec) begin
            n_bad++;
            $display("FAIL reset got=%b exp=%b", got, exp_vec);
        end
    endtask

    task automatic test_blink();
        for (int i = 0; i < 90; i++) begin
            step(1, 0, 0);
            n_vec++;
            if (got !== exp_vec) begin
                n_bad++;
                $display("FAIL blink t=%0d got=%b exp=%b", m_t, got, exp_vec);
            end
        end
    endtask

    task automatic test_move_hidden();
        int guard = 0;
        while (!(!m_cur && m_t % PER >= 3 && m_t % PER <= 10) && guard < 100) begin
            step(1, 0, 0);
            guard++;
            n_vec++;
            if (got !== exp_vec) begin
                n_bad++;
                $display("FAIL move_hidden_pre t=%0d got=%b exp=%b", m_t, got, exp_vec);
            end
        end
        if (guard >= 100) begin
            n_bad++;
            $display("FAIL move_hidden_timeout waited=%0d limit=100", guard);
        end
        step(1, 1, 0);
        n_vec++;
        if (got !== 5'b01110) begin
            n_bad++;
            $display("FAIL move_hidden got=%b exp=01110", got);
        end
        for (int i = 0; i < 45; i++) begin
            step(1, 0, 0);
            n_vec++;
            if (got !== exp_vec) begin
                n_bad++;
                $display("FAIL move_hidden_post t=%0d got=%b exp=%b", m_t, got, exp_vec);
            end
        end
    endtask

    task automatic test_move_done();
        int guard = 0;
        while (m_t % PER != DLY + 1 && guard < 30) begin
            step(1, 0, 0);
            guard++;
        end
        n_vec++;
        if (delay_done !== 1'b0 || guard >= 30) begin
            n_bad++;
            $display("FAIL move_done_pre done=%b waited=%0d", delay_done, guard);
        end
        step(1, 1, 0);
        n_vec++;
        if (got !== exp_vec || delay_rst !== 1'b1) begin
            n_bad++;
            $display("FAIL move_done got=%b exp=%b", got, exp_vec);
        end
        for (int i = 0; i < 30; i++) begin
            step(1, 0, 0);
            n_vec++;
            if (got !== exp_vec) begin
                n_bad++;
                $display("FAIL move_done_post t=%0d got=%b exp=%b", m_t, got, exp_vec);
            end
        end
    endtask

    task automatic test_en_drop();
        int guard = 0;
        while (m_t % PER != 5 && guard < 30) begin
            step(1, 0, 0);
            guard++;
        end
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0);
            n_vec++;
            if (got !== exp_vec || got[4] !== 1'b0) begin
                n_bad++;
                $display("FAIL en_drop i=%0d got=%b exp=%b", i, got, exp_vec);
            end
        end
    endtask

    task automatic test_rst_toggle();
        int guard = 0;
        step(1, 0, 0);
        while (m_t != PER * (VIS - 1) + PER - 1 && guard < 60) begin
            step(1, 0, 0);
            guard++;
        end
        step(1, 0, 1);
        n_vec++;
        if (got !== 5'b01100) begin
            n_bad++;
            $display("FAIL rst_toggle got=%b exp=01100", got);
        end
        step(0, 0, 0);
        n_vec++;
        if (got !== exp_vec) begin
            n_bad++;
            $display("FAIL rst_toggle_after got=%b exp=%b", got, exp_vec);
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 160; i++) begin
            step(1, 0, 0);
            n_vec++;
            if (got !== exp_vec) begin
                n_bad++;
                $display("FAIL idle_run t=%0d got=%b exp=%b", m_t, got, exp_vec);
            end
        end
        step(1, 1, 0);
        n_vec++;
        if (got !== exp_vec || idle !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_move got=%b exp=%b", got, exp_vec);
        end
        for (int i = 0; i < 40; i++) begin
            step(1, 0, 0);
            n_vec++;
            if (got !== exp_vec) begin
                n_bad++;
                $display("FAIL idle_resume t=%0d got=%b exp=%b", m_t, got, exp_vec);
            end
        end
    endtask

    task automatic test_random();
        logic e, mv, r;
        for (int i = 0; i < 1500; i++) begin
            e  = ($urandom_range(0, 99) != 0);
            mv = ($urandom_range(0, 59) == 0);
            r  = ($urandom_range(0, 399) == 0);
            step(e, mv, r);
            n_vec++;
            if (got !== exp_vec) begin
                n_bad++;
                $display("FAIL random i=%0d t=%0d got=%b exp=%b", i, m_t, got, exp_vec);
            end
        end
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        en = 1'b0;
        move = 1'b0;
        delay_done = 1'b0;
        test_reset();
        test_blink();
        test_move_hidden();
        test_move_done();
        test_en_drop();
        test_rst_toggle();
        test_idle();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
